// File: rtl/xgmac_cfg_master_pkg.sv
// ----------------------------------------------------------------------------
// xgmac_cfg_master_pkg
//
// Shared definitions for the 10G MAC/PHY configuration bus master:
//   - command op codes as they appear in the command table
//   - FSM state encoding of the sequencer
//   - packed command entry struct
//   - default bring-up command table used by xgmac_cfg_rom
// No ports; imported by xgmac_cfg_rom and xgmac_cfg_master.
// ----------------------------------------------------------------------------
package xgmac_cfg_master_pkg;

    // Command op codes as stored in the table
    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_POLL  = 2'b10,
        OP_END   = 2'b11
    } cmd_op_e;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_CHECK  = 3'd3,
        ST_GAP    = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    // One command table entry
    typedef struct packed {
        cmd_op_e     op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] mask;
    } cmd_t;

    // Default sequencer dimensions
    localparam int DEF_NUM_CMDS = 8;
    localparam int DEF_TIMEOUT  = 255;
    localparam int DEF_POLL_MAX = 16;

    // Default bring-up table register addresses and values
    localparam logic [31:0] REG_CTRL      = 32'h0000_0404;
    localparam logic [31:0] REG_CFG       = 32'h0000_0408;
    localparam logic [31:0] REG_VERSION   = 32'h0000_0200;
    localparam logic [31:0] CTRL_SOFT_RST = 32'h8000_0000;
    localparam logic [31:0] CFG_TXRX_EN   = 32'h1000_0000;

    // Default bring-up sequence: pulse soft reset, wait for it to
    // self-clear, enable the datapath, then read the version register.
    // Any index past the last entry reads back as END.
    function automatic cmd_t default_cmd(input logic [7:0] idx);
        cmd_t c;
        c = '{OP_END, 32'h0, 32'h0, 32'h0};
        case (idx)
            8'd0: c = '{OP_WRITE, REG_CTRL,    CTRL_SOFT_RST, 32'h0};
            8'd1: c = '{OP_POLL,  REG_CTRL,    32'h0,         CTRL_SOFT_RST};
            8'd2: c = '{OP_WRITE, REG_CFG,     CFG_TXRX_EN,   32'h0};
            8'd3: c = '{OP_READ,  REG_VERSION, 32'h0,         32'h0};
            default: c = '{OP_END, 32'h0, 32'h0, 32'h0};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/xgmac_cfg_rom.sv
// ----------------------------------------------------------------------------
// xgmac_cfg_rom
//
// Combinational command table lookup for the configuration bus master.
// Maps a table index to the {op, addr, data, mask} fields of that entry.
//
// Ports:
//   idx   in   8   table index from the sequencer
//   op    out  2   op code (WRITE/READ/POLL/END)
//   addr  out  32  register address
//   data  out  32  write data or POLL expect value
//   mask  out  32  POLL compare mask
// ----------------------------------------------------------------------------
module xgmac_cfg_rom
    import xgmac_cfg_master_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [1:0]  op,
    output logic [31:0] addr,
    output logic [31:0] data,
    output logic [31:0] mask
);

    cmd_t entry;

    // Pure lookup into the default bring-up table
    always_comb begin
        entry = default_cmd(idx);
    end

    assign op   = entry.op;
    assign addr = entry.addr;
    assign data = entry.data;
    assign mask = entry.mask;

endmodule

// File: rtl/xgmac_cfg_master.sv
// ----------------------------------------------------------------------------
// xgmac_cfg_master
//
// IPIF bus master feeding the bus2ip_* slave port of the 10G MAC/PHY core.
// After a start pulse it walks a command table (WRITE / READ / POLL / END),
// runs one register transaction per entry and checks acks, bus errors and
// poll results. Ends in DONE (sticky done) or ERR (sticky error + err_idx).
//
// Ports:
//   clk           in   1   core clock
//   rst_n         in   1   synchronous active-low reset
//   start         in   1   begin sequence (ignored while busy)
//   busy          out  1   sequence running
//   done          out  1   sticky, table completed without error
//   error         out  1   sticky, bus error / timeout / poll exhaustion
//   err_idx       out  8   table index of the failing entry
//   rd_data_last  out  32  data captured on the most recent rdack
//   cmd_idx       out  8   current table index
//   cmd_op        in   2   external table op (used when C_EXT_TABLE=1)
//   cmd_addr      in   32  external table address
//   cmd_data      in   32  external table data / POLL expect
//   cmd_mask      in   32  external table POLL mask
//   bus2ip_addr   out  32  address, stable while cs=1
//   bus2ip_data   out  32  write data, 0 on reads
//   bus2ip_cs     out  1   transaction strobe
//   bus2ip_rnw    out  1   1 read, 0 write
//   ip2bus_data   in   32  read data, valid with rdack
//   ip2bus_rdack  in   1   read complete
//   ip2bus_wrack  in   1   write complete
//   ip2bus_error  in   1   qualifies the ack in the same cycle
// ----------------------------------------------------------------------------
module xgmac_cfg_master
    import xgmac_cfg_master_pkg::*;
#(
    parameter int C_NUM_CMDS  = DEF_NUM_CMDS,
    parameter int C_TIMEOUT   = DEF_TIMEOUT,
    parameter int C_POLL_MAX  = DEF_POLL_MAX,
    parameter bit C_EXT_TABLE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  err_idx,
    output logic [31:0] rd_data_last,
    output logic [7:0]  cmd_idx,
    input  logic [1:0]  cmd_op,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_data,
    input  logic [31:0] cmd_mask,
    output logic [31:0] bus2ip_addr,
    output logic [31:0] bus2ip_data,
    output logic        bus2ip_cs,
    output logic        bus2ip_rnw,
    input  logic [31:0] ip2bus_data,
    input  logic        ip2bus_rdack,
    input  logic        ip2bus_wrack,
    input  logic        ip2bus_error
);

    localparam int TMO_W  = $clog2(C_TIMEOUT + 1);
    localparam int POLL_W = $clog2(C_POLL_MAX + 1);

    // Timeout fires on the edge where the C_TIMEOUT-th cs-high cycle ends
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(C_TIMEOUT - 1);
    localparam logic [POLL_W-1:0] POLL_LIMIT = POLL_W'(C_POLL_MAX);
    localparam logic [7:0]        IDX_END    = 8'(C_NUM_CMDS);

    state_e              state;
    cmd_op_e             op_r;
    logic [31:0]         data_r;
    logic [31:0]         mask_r;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [POLL_W-1:0]   poll_cnt;

    logic [1:0]          rom_op;
    logic [31:0]         rom_addr;
    logic [31:0]         rom_data;
    logic [31:0]         rom_mask;

    cmd_op_e             sel_op;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_data;
    logic [31:0]         sel_mask;

    logic                ack_hit;
    logic                poll_hit;
    logic [POLL_W-1:0]   poll_next;

    xgmac_cfg_rom u_rom (
        .idx  (cmd_idx),
        .op   (rom_op),
        .addr (rom_addr),
        .data (rom_data),
        .mask (rom_mask)
    );

    // Table source select: the cmd_* ports let a bench or a higher level
    // supply its own table in place of the built-in bring-up ROM.
    assign sel_op   = cmd_op_e'(C_EXT_TABLE ? cmd_op : rom_op);
    assign sel_addr = C_EXT_TABLE ? cmd_addr : rom_addr;
    assign sel_data = C_EXT_TABLE ? cmd_data : rom_data;
    assign sel_mask = C_EXT_TABLE ? cmd_mask : rom_mask;

    // Only the ack that matches the transaction direction completes it;
    // a stray ack of the other kind is simply ignored.
    assign ack_hit   = bus2ip_rnw ? ip2bus_rdack : ip2bus_wrack;
    assign poll_hit  = (rd_data_last & mask_r) == (data_r & mask_r);
    assign poll_next = poll_cnt + 1'b1;

    // Sequencer FSM with all IPIF outputs and status flags registered.
    // Every path into ERR drops cs, clears busy and latches the index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            op_r         <= OP_END;
            data_r       <= '0;
            mask_r       <= '0;
            tmo_cnt      <= '0;
            poll_cnt     <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_idx      <= '0;
            rd_data_last <= '0;
            cmd_idx      <= '0;
            bus2ip_cs    <= 1'b0;
            bus2ip_rnw   <= 1'b1;
            bus2ip_addr  <= '0;
            bus2ip_data  <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        busy     <= 1'b1;
                        cmd_idx  <= '0;
                        poll_cnt <= '0;
                        state    <= ST_FETCH;
                    end
                end

                ST_FETCH: begin
                    op_r   <= sel_op;
                    data_r <= sel_data;
                    mask_r <= sel_mask;
                    if (sel_op == OP_END || cmd_idx == IDX_END) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        bus2ip_addr <= sel_addr;
                        bus2ip_data <= (sel_op == OP_WRITE) ? sel_data : 32'h0;
                        bus2ip_rnw  <= (sel_op != OP_WRITE);
                        bus2ip_cs   <= 1'b1;
                        tmo_cnt     <= '0;
                        poll_cnt    <= '0;
                        state       <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    // A matching ack beats a timeout landing in the same cycle
                    if (ack_hit) begin
                        bus2ip_cs <= 1'b0;
                        if (ip2bus_error) begin
                            busy    <= 1'b0;
                            error   <= 1'b1;
                            err_idx <= cmd_idx;
                            state   <= ST_ERR;
                        end else begin
                            if (bus2ip_rnw) begin
                                rd_data_last <= ip2bus_data;
                            end
                            if (op_r == OP_POLL) begin
                                state <= ST_CHECK;
                            end else begin
                                cmd_idx <= cmd_idx + 1'b1;
                                state   <= ST_FETCH;
                            end
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus2ip_cs <= 1'b0;
                        busy      <= 1'b0;
                        error     <= 1'b1;
                        err_idx   <= cmd_idx;
                        state     <= ST_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                ST_CHECK: begin
                    if (poll_hit) begin
                        poll_cnt <= '0;
                        cmd_idx  <= cmd_idx + 1'b1;
                        state    <= ST_FETCH;
                    end else if (poll_next == POLL_LIMIT) begin
                        poll_cnt <= poll_next;
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        err_idx  <= cmd_idx;
                        state    <= ST_ERR;
                    end else begin
                        poll_cnt <= poll_next;
                        state    <= ST_GAP;
                    end
                end

                ST_GAP: begin
                    // Re-issue the same POLL read after one idle cycle
                    bus2ip_cs <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= ST_ACCESS;
                end

                default: begin
                    bus2ip_cs <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xgmac_cfg_master.sv
// ----------------------------------------------------------------------------
// tb_xgmac_cfg_master
//
// Directed bench for xgmac_cfg_master. The command table is supplied through
// the cmd_* ports from bench arrays; a small IPIF slave model answers cs with
// configurable wait states, read data sequences, bus errors, hangs and stray
// rdacks, and keeps pulse / cs-high counters for the checks.
// ----------------------------------------------------------------------------
module tb_xgmac_cfg_master;
    import xgmac_cfg_master_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  err_idx;
    logic [31:0] rd_data_last;
    logic [7:0]  cmd_idx;
    logic [1:0]  cmd_op;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_data;
    logic [31:0] cmd_mask;
    logic [31:0] bus2ip_addr;
    logic [31:0] bus2ip_data;
    logic        bus2ip_cs;
    logic        bus2ip_rnw;
    logic [31:0] ip2bus_data;
    logic        ip2bus_rdack;
    logic        ip2bus_wrack;
    logic        ip2bus_error;

    // Bench-side command table
    logic [1:0]  tbl_op   [0:7];
    logic [31:0] tbl_addr [0:7];
    logic [31:0] tbl_data [0:7];
    logic [31:0] tbl_mask [0:7];

    // Slave model configuration (written by the main sequence only)
    int          slave_wait     = 0;
    bit          slave_ack_en   = 1'b1;
    bit          slave_err_en   = 1'b0;
    logic [31:0] slave_err_addr = 32'hFFFF_FFFF;
    logic [31:0] slave_hang_addr = 32'hFFFF_FFFF;
    bit          stray_rdack    = 1'b0;
    logic [31:0] rd_default     = 32'h0;
    logic [31:0] rd_seq [0:31];
    int          rd_seq_len     = 0;
    int          rd_seq_base    = 0;

    // Slave model observations (written by the slave process only)
    int          cs_pulses      = 0;
    int          cs_high_cycles = 0;
    int          txn_cycles     = 0;
    int          rd_count       = 0;
    logic        cs_prev        = 1'b0;
    logic [31:0] obs_addr       = 32'h0;
    logic [31:0] obs_data       = 32'h0;
    logic        obs_rnw        = 1'b0;

    int          tests_run      = 0;
    int          tests_failed   = 0;

    xgmac_cfg_master #(
        .C_NUM_CMDS  (8),
        .C_TIMEOUT   (255),
        .C_POLL_MAX  (16),
        .C_EXT_TABLE (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .err_idx      (err_idx),
        .rd_data_last (rd_data_last),
        .cmd_idx      (cmd_idx),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .cmd_mask     (cmd_mask),
        .bus2ip_addr  (bus2ip_addr),
        .bus2ip_data  (bus2ip_data),
        .bus2ip_cs    (bus2ip_cs),
        .bus2ip_rnw   (bus2ip_rnw),
        .ip2bus_data  (ip2bus_data),
        .ip2bus_rdack (ip2bus_rdack),
        .ip2bus_wrack (ip2bus_wrack),
        .ip2bus_error (ip2bus_error)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global safety net so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Table lookup presented to the DUT; indices past the array read as END
    always_comb begin
        if (cmd_idx < 8'd8) begin
            cmd_op   = tbl_op[cmd_idx[2:0]];
            cmd_addr = tbl_addr[cmd_idx[2:0]];
            cmd_data = tbl_data[cmd_idx[2:0]];
            cmd_mask = tbl_mask[cmd_idx[2:0]];
        end else begin
            cmd_op   = 2'b11;
            cmd_addr = 32'h0;
            cmd_data = 32'h0;
            cmd_mask = 32'h0;
        end
    end

    // IPIF slave model: acts at the falling edge so the DUT samples its
    // responses at the next rising edge. Ack arrives after slave_wait idle
    // cs cycles unless the address is the hang address or acks are off.
    initial begin
        ip2bus_data  = 32'h0;
        ip2bus_rdack = 1'b0;
        ip2bus_wrack = 1'b0;
        ip2bus_error = 1'b0;
        forever begin
            @(negedge clk);
            if (bus2ip_cs === 1'b1) begin
                if (cs_prev !== 1'b1) cs_pulses++;
                cs_high_cycles++;
                txn_cycles++;
                obs_addr = bus2ip_addr;
                obs_data = bus2ip_data;
                obs_rnw  = bus2ip_rnw;
                if (slave_ack_en && bus2ip_addr != slave_hang_addr &&
                    txn_cycles == slave_wait + 1) begin
                    ip2bus_error = slave_err_en && (bus2ip_addr == slave_err_addr);
                    if (bus2ip_rnw) begin
                        ip2bus_rdack = 1'b1;
                        ip2bus_wrack = 1'b0;
                        if (rd_count - rd_seq_base < rd_seq_len)
                            ip2bus_data = rd_seq[rd_count - rd_seq_base];
                        else
                            ip2bus_data = rd_default;
                        rd_count++;
                    end else begin
                        ip2bus_wrack = 1'b1;
                        ip2bus_rdack = 1'b0;
                        ip2bus_data  = 32'h0;
                    end
                end else begin
                    ip2bus_wrack = 1'b0;
                    ip2bus_error = 1'b0;
                    ip2bus_data  = 32'h0;
                    ip2bus_rdack = stray_rdack && !bus2ip_rnw;
                end
            end else begin
                txn_cycles   = 0;
                ip2bus_rdack = 1'b0;
                ip2bus_wrack = 1'b0;
                ip2bus_error = 1'b0;
                ip2bus_data  = 32'h0;
            end
            cs_prev = bus2ip_cs;
        end
    end

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One-cycle start pulse; returns at the falling edge after it was sampled
    task automatic applyStimulus();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for the sequence to finish; an expired budget fails
    task automatic waitIdle(input int budget, input string tag);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 32'(busy), 32'd0);
    endtask

    task automatic clearTable();
        for (int i = 0; i < 8; i++) begin
            tbl_op[i]   = 2'b11;
            tbl_addr[i] = 32'h0;
            tbl_data[i] = 32'h0;
            tbl_mask[i] = 32'h0;
        end
    endtask

    task automatic loadEntry(input int i, input logic [1:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] mask);
        tbl_op[i]   = op;
        tbl_addr[i] = addr;
        tbl_data[i] = data;
        tbl_mask[i] = mask;
    endtask

    // Main directed sequence
    initial begin
        int p0;
        int h0;
        rst_n = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 32; i++) rd_seq[i] = 32'h0;
        clearTable();
        repeat (3) @(negedge clk);

        // Reset state
        checkOutput("rst_busy",    32'(busy), 32'd0);
        checkOutput("rst_done",    32'(done), 32'd0);
        checkOutput("rst_error",   32'(error), 32'd0);
        checkOutput("rst_err_idx", 32'(err_idx), 32'd0);
        checkOutput("rst_rd_last", rd_data_last, 32'h0);
        checkOutput("rst_cmd_idx", 32'(cmd_idx), 32'd0);
        checkOutput("rst_cs",      32'(bus2ip_cs), 32'd0);
        checkOutput("rst_rnw",     32'(bus2ip_rnw), 32'd1);
        checkOutput("rst_addr",    bus2ip_addr, 32'h0);
        checkOutput("rst_data",    bus2ip_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single zero-wait WRITE, cycle-exact latency
        clearTable();
        loadEntry(0, OP_WRITE, 32'h0000_0404, 32'h8000_0000, 32'h0);
        p0 = cs_pulses;
        applyStimulus();
        checkOutput("t1_busy_n1",  32'(busy), 32'd1);
        checkOutput("t1_cs_n1",    32'(bus2ip_cs), 32'd0);
        @(negedge clk);
        checkOutput("t1_cs_n2",    32'(bus2ip_cs), 32'd1);
        checkOutput("t1_addr",     bus2ip_addr, 32'h0000_0404);
        checkOutput("t1_rnw",      32'(bus2ip_rnw), 32'd0);
        checkOutput("t1_wdata",    bus2ip_data, 32'h8000_0000);
        @(negedge clk);
        checkOutput("t1_cs_n3",    32'(bus2ip_cs), 32'd0);
        checkOutput("t1_done_n3",  32'(done), 32'd0);
        @(negedge clk);
        checkOutput("t1_done_n4",  32'(done), 32'd1);
        checkOutput("t1_busy_n4",  32'(busy), 32'd0);
        checkOutput("t1_error",    32'(error), 32'd0);
        checkOutput("t1_pulses",   32'(cs_pulses - p0), 32'd1);

        // 2: READ with 3 wait cycles
        clearTable();
        loadEntry(0, OP_READ, 32'h0000_0200, 32'h0, 32'h0);
        slave_wait = 3;
        rd_seq_len = 0;
        rd_default = 32'hDEAD_BEEF;
        h0 = cs_high_cycles;
        applyStimulus();
        waitIdle(50, "t2_finish");
        checkOutput("t2_rd_last",  rd_data_last, 32'hDEAD_BEEF);
        checkOutput("t2_cs_cyc",   32'(cs_high_cycles - h0), 32'd4);
        checkOutput("t2_rd_wdata", obs_data, 32'h0);
        checkOutput("t2_rd_rnw",   32'(obs_rnw), 32'd1);
        checkOutput("t2_done",     32'(done), 32'd1);

        // 3a: POLL succeeds on the third read
        clearTable();
        loadEntry(0, OP_POLL, 32'h0000_0300, 32'h1, 32'h1);
        slave_wait  = 0;
        rd_seq[0]   = 32'h0;
        rd_seq[1]   = 32'h0;
        rd_seq[2]   = 32'h1;
        rd_seq_len  = 3;
        rd_seq_base = rd_count;
        rd_default  = 32'h0;
        p0 = cs_pulses;
        applyStimulus();
        waitIdle(100, "t3a_finish");
        checkOutput("t3a_pulses",  32'(cs_pulses - p0), 32'd3);
        checkOutput("t3a_done",    32'(done), 32'd1);
        checkOutput("t3a_error",   32'(error), 32'd0);
        checkOutput("t3a_rd_last", rd_data_last, 32'h1);
        checkOutput("t3a_addr",    obs_addr, 32'h0000_0300);

        // 3b: POLL never matches (bit 0 stays low) -> exhaustion
        rd_seq_len = 0;
        rd_default = 32'hFFFF_FFFE;
        p0 = cs_pulses;
        applyStimulus();
        waitIdle(300, "t3b_finish");
        checkOutput("t3b_error",   32'(error), 32'd1);
        checkOutput("t3b_done",    32'(done), 32'd0);
        checkOutput("t3b_pulses",  32'(cs_pulses - p0), 32'd16);
        checkOutput("t3b_err_idx", 32'(err_idx), 32'd0);

        // 4: WRITE never acked, stray rdacks must not complete it
        clearTable();
        loadEntry(0, OP_WRITE, 32'h0000_0500, 32'h0000_1234, 32'h0);
        slave_ack_en = 1'b0;
        stray_rdack  = 1'b1;
        h0 = cs_high_cycles;
        applyStimulus();
        waitIdle(400, "t4_finish");
        checkOutput("t4_error",    32'(error), 32'd1);
        checkOutput("t4_err_idx",  32'(err_idx), 32'd0);
        checkOutput("t4_cs_cyc",   32'(cs_high_cycles - h0), 32'd255);
        checkOutput("t4_done",     32'(done), 32'd0);
        slave_ack_en = 1'b1;
        stray_rdack  = 1'b0;

        // 5: bus error on entry 2, then rerun cleanly
        clearTable();
        loadEntry(0, OP_WRITE, 32'h0000_0010, 32'h0000_000A, 32'h0);
        loadEntry(1, OP_READ,  32'h0000_0020, 32'h0, 32'h0);
        loadEntry(2, OP_WRITE, 32'h0000_0030, 32'h0000_000C, 32'h0);
        rd_default     = 32'h0000_0055;
        slave_err_en   = 1'b1;
        slave_err_addr = 32'h0000_0030;
        applyStimulus();
        waitIdle(100, "t5_finish");
        checkOutput("t5_error",    32'(error), 32'd1);
        checkOutput("t5_err_idx",  32'(err_idx), 32'd2);
        checkOutput("t5_done",     32'(done), 32'd0);
        checkOutput("t5_rd_last",  rd_data_last, 32'h0000_0055);
        slave_err_en = 1'b0;
        p0 = cs_pulses;
        applyStimulus();
        checkOutput("t5_err_clr",  32'(error), 32'd0);
        checkOutput("t5_rerun_busy", 32'(busy), 32'd1);
        waitIdle(100, "t5_rerun_finish");
        checkOutput("t5_rerun_done", 32'(done), 32'd1);
        checkOutput("t5_rerun_err",  32'(error), 32'd0);
        checkOutput("t5_rerun_pulses", 32'(cs_pulses - p0), 32'd3);

        // 6: start while busy is ignored; reset mid-transaction drops cs
        clearTable();
        loadEntry(0, OP_WRITE, 32'h0000_0010, 32'h0000_0001, 32'h0);
        loadEntry(1, OP_READ,  32'h0000_0040, 32'h0, 32'h0);
        slave_hang_addr = 32'h0000_0040;
        applyStimulus();
        repeat (4) @(negedge clk);
        p0 = cs_pulses;
        applyStimulus();
        checkOutput("t6_cs_held",  32'(bus2ip_cs), 32'd1);
        checkOutput("t6_idx_held", 32'(cmd_idx), 32'd1);
        checkOutput("t6_busy",     32'(busy), 32'd1);
        checkOutput("t6_no_pulse", 32'(cs_pulses - p0), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_cs",   32'(bus2ip_cs), 32'd0);
        checkOutput("t6_rst_busy", 32'(busy), 32'd0);
        checkOutput("t6_rst_idx",  32'(cmd_idx), 32'd0);
        rst_n = 1'b1;
        slave_hang_addr = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
